// File: rtl/max7219_fb_driver.sv
`default_nettype none
// ============================================================================
// Module   : max7219_fb_driver
// Brief    : Streams a flat framebuffer to a cascaded MAX7219 8x8 array over
//            SPI, with automatic chain initialisation after reset.
// Revision : 1.0 - initial release
// ============================================================================
module max7219_fb_driver #(
    parameter int SEG_ROWS = 3,
    parameter int SEG_COLS = 2,
    parameter int CYCLES   = 1
) (
    input  logic                            i_Clk,
    input  logic                            i_Rst,
    input  logic [SEG_ROWS*SEG_COLS*64-1:0] i_FB,
    input  logic [3:0]                      i_Intensity,
    input  logic                            i_Update,
    output logic                            o_Busy,
    output logic                            o_Frame_Done,
    output logic                            o_SPI_Stb,
    output logic                            o_SPI_Clk,
    output logic                            o_SPI_Din
);
    localparam int c_num_dev = SEG_ROWS * SEG_COLS;
    localparam int c_fb_w    = c_num_dev * 64;
    localparam int c_row_w   = SEG_COLS * 8;
    localparam int c_sr_w    = c_num_dev * 16;
    localparam int c_bit_w   = $clog2(c_sr_w);
    localparam int c_div_w   = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(c_sr_w - 1);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CYCLES - 1);

    localparam logic [2:0] c_st_init  = 3'd0;
    localparam logic [2:0] c_st_idle  = 3'd1;
    localparam logic [2:0] c_st_snap  = 3'd2;
    localparam logic [2:0] c_st_shift = 3'd3;
    localparam logic [2:0] c_st_latch = 3'd4;
    localparam logic [2:0] c_st_gap   = 3'd5;

    logic [2:0]         r_state;
    logic               r_init_mode;
    logic [3:0]         r_xfer;
    logic [c_div_w-1:0] r_div;
    logic [c_bit_w-1:0] r_bit;
    logic [c_sr_w-1:0]  r_shift;
    logic [c_fb_w-1:0]  r_fb;
    logic [3:0]         r_int;
    logic               r_pending;
    logic               r_busy;
    logic               r_done;
    logic               r_stb;
    logic               r_sclk;
    logic               r_din;

    // Whole-chain payload for one transfer; device k occupies bits [16k +: 16]
    // so the MSB end (device N-1) leaves the shifter first.
    function automatic logic [c_sr_w-1:0] f_build(input logic is_init, input logic [3:0] idx,
                                                  input logic [c_fb_w-1:0] fb,
                                                  input logic [3:0] inten);
        logic [15:0]       w_bc;
        logic [c_sr_w-1:0] w_v;
        w_v = '0;
        if (is_init) begin
            case (idx)
                4'd0:    w_bc = 16'h0F00;
                4'd1:    w_bc = 16'h0B07;
                4'd2:    w_bc = 16'h0900;
                4'd3:    w_bc = {12'h0A0, inten};
                default: w_bc = 16'h0C01;
            endcase
        end else begin
            w_bc = {12'h0A0, inten};
        end
        if (!is_init && idx != 4'd0) begin
            for (int r = 0; r < SEG_ROWS; r++) begin
                for (int c = 0; c < SEG_COLS; c++) begin
                    w_v[16*(r*SEG_COLS+c) +: 16] =
                        {4'h0, idx, fb[(8*r + int'(idx) - 1)*c_row_w + 8*c +: 8]};
                end
            end
        end else begin
            for (int k = 0; k < c_num_dev; k++) w_v[16*k +: 16] = w_bc;
        end
        return w_v;
    endfunction

    logic              w_ld_init;
    logic [3:0]        w_ld_idx;
    logic [3:0]        w_ld_int;
    logic [c_sr_w-1:0] w_load;
    logic              w_last_xfer;

    always_comb begin
        w_ld_init   = (r_state == c_st_init) || (r_state == c_st_gap && r_init_mode);
        w_ld_idx    = (r_state == c_st_gap) ? (r_xfer + 4'd1) : 4'd0;
        w_ld_int    = (r_state == c_st_gap && !r_init_mode) ? r_int : i_Intensity;
        w_load      = f_build(w_ld_init, w_ld_idx, r_fb, w_ld_int);
        w_last_xfer = (r_xfer == (r_init_mode ? 4'd4 : 4'd8));
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_state     <= c_st_init;
            r_init_mode <= 1'b1;
            r_xfer      <= 4'd0;
            r_div       <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_fb        <= '0;
            r_int       <= 4'd0;
            r_pending   <= 1'b0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_stb       <= 1'b1;
            r_sclk      <= 1'b0;
            r_din       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_Update && r_state != c_st_idle) r_pending <= 1'b1;
            case (r_state)
                c_st_init: begin
                    r_init_mode <= 1'b1;
                    r_xfer      <= 4'd0;
                    r_shift     <= w_load;
                    r_din       <= w_load[c_sr_w-1];
                    r_stb       <= 1'b0;
                    r_sclk      <= 1'b0;
                    r_div       <= '0;
                    r_bit       <= '0;
                    r_state     <= c_st_shift;
                end
                c_st_idle: begin
                    if (i_Update) begin
                        r_busy  <= 1'b1;
                        r_state <= c_st_snap;
                    end
                end
                c_st_snap: begin
                    r_fb        <= i_FB;
                    r_int       <= i_Intensity;
                    r_init_mode <= 1'b0;
                    r_xfer      <= 4'd0;
                    r_shift     <= w_load;
                    r_din       <= w_load[c_sr_w-1];
                    r_stb       <= 1'b0;
                    r_sclk      <= 1'b0;
                    r_div       <= '0;
                    r_bit       <= '0;
                    r_state     <= c_st_shift;
                end
                c_st_shift: begin
                    if (r_div == c_div_last) begin
                        r_div <= '0;
                        if (!r_sclk) begin
                            r_sclk <= 1'b1;
                        end else begin
                            // Falling SCLK is the only point where Din advances
                            r_sclk <= 1'b0;
                            if (r_bit == c_bit_last) begin
                                r_state <= c_st_latch;
                            end else begin
                                r_bit   <= r_bit + 1'b1;
                                r_shift <= {r_shift[c_sr_w-2:0], 1'b0};
                                r_din   <= r_shift[c_sr_w-2];
                            end
                        end
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                c_st_latch: begin
                    if (r_div == c_div_last) begin
                        r_div   <= '0;
                        r_stb   <= 1'b1;
                        r_state <= c_st_gap;
                    end else begin
                        r_div <= r_div + 1'b1;
                    end
                end
                c_st_gap: begin
                    if (r_div != c_div_last) begin
                        r_div <= r_div + 1'b1;
                    end else if (!w_last_xfer) begin
                        r_xfer  <= r_xfer + 4'd1;
                        r_shift <= w_load;
                        r_din   <= w_load[c_sr_w-1];
                        r_stb   <= 1'b0;
                        r_sclk  <= 1'b0;
                        r_div   <= '0;
                        r_bit   <= '0;
                        r_state <= c_st_shift;
                    end else begin
                        r_done      <= !r_init_mode;
                        r_init_mode <= 1'b0;
                        r_div       <= '0;
                        if (r_pending || i_Update) begin
                            r_pending <= 1'b0;
                            r_state   <= c_st_snap;
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= c_st_idle;
                        end
                    end
                end
                default: r_state <= c_st_init;
            endcase
        end
    end

    assign o_Busy       = r_busy;
    assign o_Frame_Done = r_done;
    assign o_SPI_Stb    = r_stb;
    assign o_SPI_Clk    = r_sclk;
    assign o_SPI_Din    = r_din;
endmodule
`default_nettype wire

// File: tb/tb_max7219_fb_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_max7219_fb_driver
// Brief    : Directed self-checking bench for max7219_fb_driver (3x2, CYCLES=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_max7219_fb_driver;
    localparam int c_xfer_low = 193;   // Stb-low cycles per transfer: 32*6+1
    localparam int c_bits     = 96;

    logic         r_clk = 1'b0;
    logic         r_rst_n;
    logic [383:0] r_fb;
    logic [3:0]   r_inten;
    logic         r_upd;
    logic         w_busy, w_done, w_stb, w_sclk, w_din;

    always #5 r_clk = ~r_clk;

    max7219_fb_driver #(.SEG_ROWS(3), .SEG_COLS(2), .CYCLES(1)) u_dut (
        .i_Clk        (r_clk),
        .i_Rst        (r_rst_n),
        .i_FB         (r_fb),
        .i_Intensity  (r_inten),
        .i_Update     (r_upd),
        .o_Busy       (w_busy),
        .o_Frame_Done (w_done),
        .o_SPI_Stb    (w_stb),
        .o_SPI_Clk    (w_sclk),
        .o_SPI_Din    (w_din)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // SPI receiver: one record per Stb rising edge
    logic [95:0] cap_q[$];
    int          len_q[$];
    int          nb_q[$];
    logic [95:0] cap;
    int          nb = 0, low = 0, din_viol = 0;
    logic        prev_sclk = 1'b0, prev_stb = 1'b1, prev_din = 1'b0;

    always @(negedge r_clk) begin
        if (!r_rst_n) begin
            nb = 0; low = 0; prev_sclk = 1'b0; prev_stb = 1'b1; prev_din = 1'b0;
        end else begin
            if (!w_stb) low++;
            if (w_sclk && w_din !== prev_din) din_viol++;
            if (w_sclk && !prev_sclk) begin
                cap = {cap[94:0], w_din};
                nb++;
            end
            if (w_stb && !prev_stb) begin
                cap_q.push_back(cap); len_q.push_back(low); nb_q.push_back(nb);
                low = 0; nb = 0;
            end
            prev_sclk = w_sclk; prev_stb = w_stb; prev_din = w_din;
        end
    end

    logic [95:0] exp_v[0:8];

    function automatic logic [95:0] rep(input logic [15:0] w);
        return {6{w}};
    endfunction

    function automatic logic [383:0] diag_fb();
        logic [383:0] v;
        v = '0;
        for (int y = 0; y < 24; y++) v[y*16 + ((y < 16) ? y : y - 16)] = 1'b1;
        return v;
    endfunction

    // Diagonal: device (r,c) lit with bit s in stripe s when c == r mod 2
    task automatic exp_diag(input logic [3:0] inten);
        exp_v[0] = rep({12'h0A0, inten});
        for (int s = 0; s < 8; s++)
            for (int k = 0; k < 6; k++)
                exp_v[s+1][16*k +: 16] = {4'h0, 4'(s+1), ((k % 2) == ((k / 2) % 2)) ? 8'(1 << s) : 8'h00};
    endtask

    task automatic exp_single(input logic [3:0] inten);
        exp_v[0] = rep({12'h0A0, inten});
        for (int s = 0; s < 8; s++)
            for (int k = 0; k < 6; k++)
                exp_v[s+1][16*k +: 16] = {4'h0, 4'(s+1), (s == 0 && k == 0) ? 8'h01 : 8'h00};
    endtask

    task automatic chk_frame(input string tag, input int base);
        logic [95:0] g;
        chk({tag, "_len"}, 128'((base < len_q.size()) ? len_q[base] : -1), 128'(c_xfer_low));
        for (int i = 0; i < 9; i++) begin
            g = (base + i < cap_q.size()) ? cap_q[base+i] : 'x;
            chk($sformatf("%s_w%0d", tag, i), g, exp_v[i]);
        end
    endtask

    task automatic clear_q();
        cap_q.delete(); len_q.delete(); nb_q.delete();
    endtask

    task automatic pulse_update();
        @(posedge r_clk) #1 r_upd = 1'b1;
        @(posedge r_clk) #1 r_upd = 1'b0;
    endtask

    task automatic wait_done(input string tag, input logic exp_busy);
        int i;
        for (i = 0; i < 4000 && w_done !== 1'b1; i++) @(negedge r_clk);
        chk({tag, "_done_seen"}, w_done, 1'b1);
        chk({tag, "_busy_at_done"}, w_busy, exp_busy);
        repeat (2) @(negedge r_clk);
    endtask

    task automatic wait_init(input string tag);
        int i;
        for (i = 0; i < 3000 && w_busy !== 1'b0; i++) @(negedge r_clk);
        chk({tag, "_busy_low"}, w_busy, 1'b0);
        repeat (2) @(negedge r_clk);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_stb"},  w_stb,  1'b1);
        chk({tag, "_sclk"}, w_sclk, 1'b0);
        chk({tag, "_din"},  w_din,  1'b0);
        chk({tag, "_busy"}, w_busy, 1'b1);
        chk({tag, "_done"}, w_done, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] init_w[5];
        int dcount, lows;
        init_w = '{16'h0F00, 16'h0B07, 16'h0900, 16'h0A05, 16'h0C01};
        r_rst_n = 1'b0; r_upd = 1'b0; r_inten = 4'h5; r_fb = '0;
        repeat (3) @(negedge r_clk);
        chk_reset_outs("rst");

        // Power-up init sequence
        @(posedge r_clk) #1 r_rst_n = 1'b1;
        wait_init("init");
        chk("init_count", 128'(cap_q.size()), 128'd5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("init_w%0d", i), (i < cap_q.size()) ? cap_q[i] : 'x, rep(init_w[i]));
        chk("init_len", 128'(len_q[0]), 128'(c_xfer_low));
        chk("init_bits", 128'(nb_q[4]), 128'(c_bits));

        // Diagonal frame
        clear_q(); r_fb = diag_fb();
        pulse_update();
        chk("diag_busy_rise", w_busy, 1'b1);
        wait_done("diag", 1'b0);
        chk("diag_count", 128'(cap_q.size()), 128'd9);
        exp_diag(4'h5); chk_frame("diag", 0);

        // Single pixel at (0,0)
        clear_q(); r_fb = 384'd1; r_inten = 4'hC;
        pulse_update();
        wait_done("single", 1'b0);
        exp_single(4'hC); chk_frame("single", 0);

        // Inputs change one cycle after SNAP: frame keeps the snapshot
        clear_q(); r_fb = diag_fb(); r_inten = 4'h9;
        pulse_update();
        @(posedge r_clk) #1 r_fb = '1; r_inten = 4'h3;
        wait_done("snap", 1'b0);
        exp_diag(4'h9); chk_frame("snap", 0);

        // Three requests during a frame merge into one follow-on frame
        clear_q(); r_fb = diag_fb(); r_inten = 4'h2;
        pulse_update();
        for (int p = 0; p < 3; p++) begin
            repeat (150) @(posedge r_clk);
            pulse_update();
        end
        dcount = 0; lows = 0;
        for (int i = 0; i < 5000 && dcount < 2; i++) begin
            @(negedge r_clk);
            if (w_done) dcount++;
            if (!w_busy && dcount < 2) lows++;
        end
        for (int i = 0; i < 2000; i++) begin
            @(negedge r_clk);
            if (w_done) dcount++;
        end
        chk("merge_done_pulses", 128'(dcount), 128'd2);
        chk("merge_busy_gaps", 128'(lows), 128'd0);
        chk("merge_count", 128'(cap_q.size()), 128'd18);
        exp_diag(4'h2); chk_frame("merge2", 9);

        // Reset in the middle of a stripe
        clear_q();
        pulse_update();
        repeat (600) @(posedge r_clk);
        #3 r_rst_n = 1'b0;
        #1 chk_reset_outs("midrst");
        repeat (3) @(posedge r_clk);
        clear_q();
        #1 r_rst_n = 1'b1;
        wait_init("reinit");
        chk("reinit_count", 128'(cap_q.size()), 128'd5);
        chk("reinit_w0", (cap_q.size() > 0) ? cap_q[0] : 'x, rep(16'h0F00));

        chk("din_stable_while_sclk_high", 128'(din_viol), 128'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
